// File: rtl/regfile_sb.sv
// General-purpose register file with two combinational read ports, one write-back port,
// optional hardwired-zero register 0, optional write-to-read bypass and a pending-write scoreboard.

module regfile_sb #(
    parameter int WIDTH    = 6,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [WIDTH-1:0]  ra_data,
    output logic              ra_busy,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [WIDTH-1:0]  rb_data,
    output logic              rb_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              idle
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DEPTH-1:0]  ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  regs_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;
    logic [ADDR_W:0]   cnt_r;

    logic              wr_ok_s;
    logic              iss_ok_s;
    logic              same_s;
    logic [DEPTH-1:0]  wr_mask_s;
    logic [DEPTH-1:0]  iss_mask_s;
    logic [DEPTH-1:0]  pend_nxt_s;
    logic              set_s;
    logic              clr_s;
    logic [ADDR_W:0]   cnt_nxt_s;
    logic              ra_zero_s;
    logic              ra_hit_s;
    logic              rb_zero_s;
    logic              rb_hit_s;

    // Read-port data select: hardwired zero beats bypass beats stored value.
    function automatic logic [WIDTH-1:0] rd_mux(
        input logic             is_zero,
        input logic             fwd,
        input logic [WIDTH-1:0] fwd_data,
        input logic [WIDTH-1:0] stored
    );
        logic [WIDTH-1:0] res;
        if (is_zero) begin
            res = {WIDTH{1'b0}};
        end else if (fwd) begin
            res = fwd_data;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Qualified strobes; writes and issues to a hardwired-zero register are dropped.
    always_comb begin
        wr_ok_s    = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ZERO_ADDR));
        iss_ok_s   = iss_en && !((ZERO_REG != 0) && (iss_addr == ZERO_ADDR));
        same_s     = iss_ok_s && wr_ok_s && (iss_addr == wr_addr);
        wr_mask_s  = wr_ok_s  ? (ONE_HOT0 << wr_addr)  : {DEPTH{1'b0}};
        iss_mask_s = iss_ok_s ? (ONE_HOT0 << iss_addr) : {DEPTH{1'b0}};
    end

    // Scoreboard next state: the issue mask is OR-ed last so a same-address issue wins
    // over the write-back of the older instruction.
    always_comb begin
        pend_nxt_s = (pend_r & ~wr_mask_s) | iss_mask_s;
        set_s      = iss_ok_s && !pend_r[iss_addr];
        clr_s      = wr_ok_s && pend_r[wr_addr] && !same_s;
        cnt_nxt_s  = cnt_r + {{ADDR_W{1'b0}}, set_s} - {{ADDR_W{1'b0}}, clr_s};
    end

    // Read port A data and busy, including same-cycle forwarding of write-back.
    always_comb begin
        ra_zero_s = (ZERO_REG != 0) && (ra_addr == ZERO_ADDR);
        ra_hit_s  = (BYPASS != 0) && wr_ok_s && (wr_addr == ra_addr);
        ra_data   = rd_mux(ra_zero_s, ra_hit_s, wr_data, regs_r[ra_addr]);
        ra_busy   = pend_r[ra_addr] && !(ra_hit_s && !same_s);
    end

    // Read port B data and busy, mirror of port A.
    always_comb begin
        rb_zero_s = (ZERO_REG != 0) && (rb_addr == ZERO_ADDR);
        rb_hit_s  = (BYPASS != 0) && wr_ok_s && (wr_addr == rb_addr);
        rb_data   = rd_mux(rb_zero_s, rb_hit_s, wr_data, regs_r[rb_addr]);
        rb_busy   = pend_r[rb_addr] && !(rb_hit_s && !same_s);
    end

    // Register array, pending bits and pending count; reset discards in-flight state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            pend_r <= {DEPTH{1'b0}};
            cnt_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                regs_r[wr_addr] <= wr_data;
            end else begin
                regs_r[wr_addr] <= regs_r[wr_addr];
            end
            pend_r <= pend_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign pend_cnt = cnt_r;
    assign idle     = (cnt_r == {(ADDR_W+1){1'b0}});

    regfile_sb_chk #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk    (clk),
        .reset  (reset),
        .pend   (pend_r),
        .cnt    (cnt_r)
    );

endmodule

// Consistency checker: the registered pending count must always equal the popcount of the
// pending bits.
module regfile_sb_chk #(
    parameter int ADDR_W = 3
) (
    input logic                   clk,
    input logic                   reset,
    input logic [(1<<ADDR_W)-1:0] pend,
    input logic [ADDR_W:0]        cnt
);

    function automatic logic [ADDR_W:0] popcount(input logic [(1<<ADDR_W)-1:0] v);
        logic [ADDR_W:0] acc;
        acc = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            acc = acc + {{ADDR_W{1'b0}}, v[i]};
        end
        return acc;
    endfunction

    // Sampled out of reset on every rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (cnt == popcount(pend));
        end
    end

endmodule
